// File: rtl/threshold_cfg_ctrl_pkg.sv
// Shared field codes, FSM encoding and reset defaults for the HSV threshold configuration path.
// The defaults are also the reset values used by the threshold stage itself.
package threshold_cfg_ctrl_pkg;

    localparam logic [1:0] FLD_H_HI = 2'b00;
    localparam logic [1:0] FLD_H_LO = 2'b01;
    localparam logic [1:0] FLD_S    = 2'b10;
    localparam logic [1:0] FLD_V    = 2'b11;

    localparam int unsigned HueMaxDef = 359;
    localparam int unsigned DefHHi    = 310;
    localparam int unsigned DefHLo    = 50;
    localparam int unsigned DefS      = 95;
    localparam int unsigned DefV      = 80;

    typedef enum logic [1:0] {
        StIdle,
        StWaitGap,
        StWrAssert,
        StWrHold
    } state_e;

    // Commits walk the dirty mask from field 00 upward.
    function automatic logic [1:0] lowest_field(input logic [3:0] mask);
        if (mask[0]) return FLD_H_HI;
        if (mask[1]) return FLD_H_LO;
        if (mask[2]) return FLD_S;
        return FLD_V;
    endfunction

endpackage

// File: rtl/threshold_cfg_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter: one grant per cycle, pointer favours the loser.
module threshold_cfg_ctrl_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic ptr_q, ptr_d;

    always_comb begin
        gnt   = 2'b00;
        ptr_d = ptr_q;
        if (en) begin
            unique case (req)
                2'b01: begin
                    gnt   = 2'b01;
                    ptr_d = 1'b1;
                end
                2'b10: begin
                    gnt   = 2'b10;
                    ptr_d = 1'b0;
                end
                2'b11: begin
                    gnt   = ptr_q ? 2'b10 : 2'b01;
                    ptr_d = ~ptr_q;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) ptr_q <= 1'b0;
        else     ptr_q <= ptr_d;
    end

endmodule

// File: rtl/threshold_cfg_ctrl.sv
// Shadows threshold field updates from two requesters and commits dirty fields to the
// threshold stage only inside the inter-frame gap, as vld-then-hold write pairs.
module threshold_cfg_ctrl
    import threshold_cfg_ctrl_pkg::*;
#(
    parameter int unsigned HUE_MAX       = HueMaxDef,
    parameter int unsigned DEF_H_HI      = DefHHi,
    parameter int unsigned DEF_H_LO      = DefHLo,
    parameter int unsigned DEF_S         = DefS,
    parameter int unsigned DEF_V         = DefV,
    parameter bit          INIT_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic [1:0]  req0_type,
    input  logic [8:0]  req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [1:0]  req1_type,
    input  logic [8:0]  req1_data,
    output logic        req1_ready,
    input  logic        frame_done_in,
    input  logic        pixel_valid,
    output logic [8:0]  threshold_data,
    output logic [1:0]  threshold_type,
    output logic        threshold_vld,
    output logic        commit_busy,
    output logic        cfg_pending,
    output logic        cfg_err,
    output logic [34:0] cfg_active
);

    localparam logic [8:0] HueMaxW  = 9'(HUE_MAX);
    localparam logic [8:0] DefHHiW  = 9'(DEF_H_HI);
    localparam logic [8:0] DefHLoW  = 9'(DEF_H_LO);
    localparam logic [8:0] DefSW    = 9'(DEF_S);
    localparam logic [7:0] DefVW    = 8'(DEF_V);
    localparam logic [3:0] DirtyRst = INIT_ON_RESET ? 4'b1111 : 4'b0000;

    state_e      state_q, state_d;
    logic [1:0]  sel_q, sel_d;
    logic [3:0]  dirty_q, dirty_d, dirty_rest;
    logic [8:0]  shadow_q [4];
    logic [8:0]  shadow_d [4];
    logic [8:0]  act_hhi_q, act_hlo_q, act_s_q, act_hhi_d, act_hlo_d, act_s_d;
    logic [7:0]  act_v_q, act_v_d;
    logic        fd_q, gap_q, gap_d;
    logic        err_q;
    logic [1:0]  thr_type_q;
    logic [8:0]  thr_data_q;

    logic        acc_en, acc, acc_bad;
    logic [1:0]  gnt, acc_type;
    logic [8:0]  acc_data;

    assign acc_en = (state_q == StIdle || state_q == StWaitGap) && !rst;

    threshold_cfg_ctrl_rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .en  (acc_en),
        .req ({req1_valid, req0_valid}),
        .gnt (gnt)
    );

    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];
    assign acc        = |gnt;
    assign acc_type   = gnt[1] ? req1_type : req0_type;
    assign acc_data   = gnt[1] ? req1_data : req0_data;
    assign acc_bad    = acc && !acc_type[1] && (acc_data > HueMaxW);
    assign dirty_rest = dirty_q & ~(4'b0001 << sel_q);

    // Clear beats set so a pixel in the detect cycle keeps the gap closed.
    assign gap_d = pixel_valid ? 1'b0 : ((frame_done_in && !fd_q) ? 1'b1 : gap_q);

    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        unique case (state_q)
            StIdle: if (dirty_q != 4'b0000) state_d = StWaitGap;
            StWaitGap: begin
                if (dirty_q == 4'b0000) begin
                    state_d = StIdle;
                end else if (gap_q) begin
                    state_d = StWrAssert;
                    sel_d   = lowest_field(dirty_q);
                end
            end
            StWrAssert: state_d = StWrHold;
            StWrHold: begin
                if (dirty_rest != 4'b0000) begin
                    state_d = StWrAssert;
                    sel_d   = lowest_field(dirty_rest);
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        threshold_vld  = (state_q == StWrAssert);
        commit_busy    = (state_q == StWrAssert) || (state_q == StWrHold);
        threshold_type = threshold_vld ? sel_q : thr_type_q;
        threshold_data = threshold_vld ? shadow_q[sel_q] : thr_data_q;
    end

    always_comb begin
        dirty_d   = dirty_q;
        shadow_d  = shadow_q;
        act_hhi_d = act_hhi_q;
        act_hlo_d = act_hlo_q;
        act_s_d   = act_s_q;
        act_v_d   = act_v_q;
        if (acc && !acc_bad) begin
            shadow_d[acc_type] = (acc_type == FLD_V) ? {1'b0, acc_data[7:0]} : acc_data;
            dirty_d[acc_type]  = 1'b1;
        end
        if (state_q == StWrHold) begin
            dirty_d[sel_q] = 1'b0;
            unique case (sel_q)
                FLD_H_HI: act_hhi_d = shadow_q[FLD_H_HI];
                FLD_H_LO: act_hlo_d = shadow_q[FLD_H_LO];
                FLD_S:    act_s_d   = shadow_q[FLD_S];
                default:  act_v_d   = shadow_q[FLD_V][7:0];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q      <= FLD_H_HI;
            dirty_q    <= DirtyRst;
            shadow_q   <= '{DefHHiW, DefHLoW, DefSW, {1'b0, DefVW}};
            act_hhi_q  <= DefHHiW;
            act_hlo_q  <= DefHLoW;
            act_s_q    <= DefSW;
            act_v_q    <= DefVW;
            fd_q       <= 1'b0;
            gap_q      <= 1'b0;
            err_q      <= 1'b0;
            thr_type_q <= 2'b00;
            thr_data_q <= 9'd0;
        end else begin
            sel_q      <= sel_d;
            dirty_q    <= dirty_d;
            shadow_q   <= shadow_d;
            act_hhi_q  <= act_hhi_d;
            act_hlo_q  <= act_hlo_d;
            act_s_q    <= act_s_d;
            act_v_q    <= act_v_d;
            fd_q       <= frame_done_in;
            gap_q      <= gap_d;
            err_q      <= acc_bad;
            if (state_q == StWrAssert) begin
                thr_type_q <= sel_q;
                thr_data_q <= shadow_q[sel_q];
            end
        end
    end

    assign cfg_pending = |dirty_q;
    assign cfg_err     = err_q;
    assign cfg_active  = {act_hhi_q, act_hlo_q, act_s_q, act_v_q};

endmodule

// File: tb/tb_threshold_cfg_ctrl.sv
// Directed bench for threshold_cfg_ctrl: gap-gated commits, arbitration, rejects, reset abort.
module tb_threshold_cfg_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic [1:0]  req0_type, req1_type;
    logic [8:0]  req0_data, req1_data;
    logic        req0_ready, req1_ready;
    logic        frame_done_in, pixel_valid;
    logic [8:0]  threshold_data;
    logic [1:0]  threshold_type;
    logic        threshold_vld, commit_busy, cfg_pending, cfg_err;
    logic [34:0] cfg_active;

    int total  = 0;
    int passed = 0;
    int fails  = 0;

    logic [8:0] def_vals [4];
    logic [8:0] t5_data  [3];
    logic [1:0] t5_type  [3];

    threshold_cfg_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .req0_valid     (req0_valid),
        .req0_type      (req0_type),
        .req0_data      (req0_data),
        .req0_ready     (req0_ready),
        .req1_valid     (req1_valid),
        .req1_type      (req1_type),
        .req1_data      (req1_data),
        .req1_ready     (req1_ready),
        .frame_done_in  (frame_done_in),
        .pixel_valid    (pixel_valid),
        .threshold_data (threshold_data),
        .threshold_type (threshold_type),
        .threshold_vld  (threshold_vld),
        .commit_busy    (commit_busy),
        .cfg_pending    (cfg_pending),
        .cfg_err        (cfg_err),
        .cfg_active     (cfg_active)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        def_vals = '{9'd310, 9'd50, 9'd95, 9'd80};
        rst = 1'b1;
        req0_valid = 1'b0; req0_type = 2'd0; req0_data = 9'd0;
        req1_valid = 1'b0; req1_type = 2'd0; req1_data = 9'd0;
        frame_done_in = 1'b0; pixel_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_vld", 64'(threshold_vld), 64'(0));
        chk("rst_type", 64'(threshold_type), 64'(0));
        chk("rst_data", 64'(threshold_data), 64'(0));
        chk("rst_err", 64'(cfg_err), 64'(0));
        chk("rst_busy", 64'(commit_busy), 64'(0));
        chk("rst_pending", 64'(cfg_pending), 64'(1));
        chk("rst_ready", 64'({req1_ready, req0_ready}), 64'(0));
        chk("rst_active", 64'(cfg_active), 64'({9'd310, 9'd50, 9'd95, 8'd80}));
        tick();
        tick();
        chk("no_gap_no_vld", 64'(threshold_vld), 64'(0));

        // 1: defaults pushed at first gap
        frame_done_in = 1'b1;
        tick();
        frame_done_in = 1'b0;
        chk("t1_detect_vld", 64'(threshold_vld), 64'(0));
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk("t1_vld", 64'(threshold_vld), 64'(i % 2));
            chk("t1_type", 64'(threshold_type), 64'((i - 1) / 2));
            chk("t1_data", 64'(threshold_data), 64'(def_vals[(i - 1) / 2]));
            chk("t1_busy", 64'(commit_busy), 64'(1));
        end
        tick();
        chk("t1_pending_end", 64'(cfg_pending), 64'(0));
        chk("t1_busy_end", 64'(commit_busy), 64'(0));
        chk("t1_type_kept", 64'(threshold_type), 64'(3));
        chk("t1_data_kept", 64'(threshold_data), 64'(80));

        // 2: mid-frame update waits for the next frame_done edge
        pixel_valid = 1'b1;
        tick();
        req0_valid = 1'b1; req0_type = 2'd2; req0_data = 9'd120;
        #1;
        chk("t2_ready", 64'(req0_ready), 64'(1));
        tick();
        req0_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            pixel_valid = (i % 2 == 1);
            tick();
            chk("t2_hold_off", 64'(threshold_vld), 64'(0));
            chk("t2_pending", 64'(cfg_pending), 64'(1));
        end
        pixel_valid = 1'b0;
        frame_done_in = 1'b1;
        tick();
        frame_done_in = 1'b0;
        chk("t2_detect_vld", 64'(threshold_vld), 64'(0));
        tick();
        chk("t2_vld", 64'(threshold_vld), 64'(1));
        chk("t2_type", 64'(threshold_type), 64'(2));
        chk("t2_data", 64'(threshold_data), 64'(120));
        tick();
        chk("t2_hold_vld", 64'(threshold_vld), 64'(0));
        chk("t2_hold_type", 64'(threshold_type), 64'(2));
        chk("t2_hold_data", 64'(threshold_data), 64'(120));
        tick();
        chk("t2_busy_end", 64'(commit_busy), 64'(0));
        chk("t2_pending_end", 64'(cfg_pending), 64'(0));
        chk("t2_active_s", 64'(cfg_active[16:8]), 64'(120));

        // 4: out-of-range hue rejected (also leaves rr pointer at 0)
        pixel_valid = 1'b1;
        req1_valid = 1'b1; req1_type = 2'd0; req1_data = 9'd400;
        #1;
        chk("t4_ready1", 64'(req1_ready), 64'(1));
        chk("t4_ready0", 64'(req0_ready), 64'(0));
        tick();
        req1_valid = 1'b0;
        chk("t4_err", 64'(cfg_err), 64'(1));
        chk("t4_pending", 64'(cfg_pending), 64'(0));
        chk("t4_active_hhi", 64'(cfg_active[34:26]), 64'(310));
        tick();
        chk("t4_err_pulse", 64'(cfg_err), 64'(0));
        chk("t4_pending2", 64'(cfg_pending), 64'(0));

        // 3: simultaneous requests alternate starting with req0
        req0_valid = 1'b1; req0_type = 2'd0; req0_data = 9'd200;
        req1_valid = 1'b1; req1_type = 2'd1; req1_data = 9'd60;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("t3_ready0", 64'(req0_ready), 64'(c != 1));
            chk("t3_ready1", 64'(req1_ready), 64'(c == 1));
            chk("t3_one_grant", 64'(req0_ready & req1_ready), 64'(0));
            tick();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // 5: three-field commit survives pixel_valid mid-commit
        req0_valid = 1'b1; req0_type = 2'd3; req0_data = 9'h1AB;
        #1;
        chk("t5_ready0", 64'(req0_ready), 64'(1));
        tick();
        req0_valid = 1'b0;
        pixel_valid = 1'b0;
        frame_done_in = 1'b1;
        tick();
        frame_done_in = 1'b0;
        tick();
        t5_type = '{2'd0, 2'd1, 2'd3};
        t5_data = '{9'd200, 9'd60, 9'd171};
        for (int k = 0; k < 3; k++) begin
            if (k == 0) begin
                req1_valid = 1'b1; req1_type = 2'd2; req1_data = 9'd7;
            end
            if (k == 1) pixel_valid = 1'b1;
            #1;
            chk("t5_vld", 64'(threshold_vld), 64'(1));
            chk("t5_type", 64'(threshold_type), 64'(t5_type[k]));
            chk("t5_data", 64'(threshold_data), 64'(t5_data[k]));
            chk("t5_ready_blocked", 64'(req1_ready), 64'(0));
            tick();
            chk("t5_hold_vld", 64'(threshold_vld), 64'(0));
            chk("t5_hold_data", 64'(threshold_data), 64'(t5_data[k]));
            chk("t5_hold_ready", 64'(req1_ready), 64'(0));
            tick();
        end
        chk("t5_busy_end", 64'(commit_busy), 64'(0));
        chk("t5_pending_end", 64'(cfg_pending), 64'(0));
        chk("t5_ready_idle", 64'(req1_ready), 64'(1));
        chk("t5_active", 64'(cfg_active), 64'({9'd200, 9'd60, 9'd120, 8'd171}));
        tick();
        req1_valid = 1'b0;

        // 6: reset during WR_ASSERT abandons the write
        pixel_valid = 1'b0;
        frame_done_in = 1'b1;
        tick();
        frame_done_in = 1'b0;
        tick();
        chk("t6_vld", 64'(threshold_vld), 64'(1));
        chk("t6_data", 64'(threshold_data), 64'(7));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_vld_abort", 64'(threshold_vld), 64'(0));
        chk("t6_busy", 64'(commit_busy), 64'(0));
        chk("t6_type", 64'(threshold_type), 64'(0));
        chk("t6_pending", 64'(cfg_pending), 64'(1));
        chk("t6_active", 64'(cfg_active), 64'({9'd310, 9'd50, 9'd95, 8'd80}));
        tick();
        frame_done_in = 1'b1;
        tick();
        frame_done_in = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk("t6_vld_seq", 64'(threshold_vld), 64'(i % 2));
            chk("t6_type_seq", 64'(threshold_type), 64'((i - 1) / 2));
            chk("t6_data_seq", 64'(threshold_data), 64'(def_vals[(i - 1) / 2]));
        end
        tick();
        chk("t6_pending_end", 64'(cfg_pending), 64'(0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
